// File: rtl/ct_spsram_512x52_ctrl_if.sv
// ct_spsram_512x52_ctrl_if: request/response channels between an LSU initiator and the SRAM controller.
interface ct_spsram_512x52_ctrl_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 52
);
   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0] req_wmask;
   logic                  rsp_vld;
   logic                  rsp_rdy;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   modport master (
      output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_rdata
   );
   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
      output req_rdy, rsp_vld, rsp_rdata
   );
endinterface

// File: rtl/ct_spsram_512x52_ctrl.sv
// ct_spsram_512x52_ctrl: registered pin driver for the 512x52 single-port SRAM with a credit-limited read FIFO.
// Define CT_SPSRAM_INIT_EN to zero-fill the whole array after every reset.
module ct_spsram_512x52_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 52,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   ct_spsram_512x52_ctrl_if.slave bus,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {RST, INIT, RUN} state_t;
   state_t                state_q, state_d;
   logic                  rd1_q, rd2_q;
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic                  cen_d, gwen_d;
   logic [DATA_WIDTH-1:0] wen_d, d_d;
   logic [ADDR_WIDTH-1:0] a_d, init_a;
   logic                  init_wr, run, acc, issue, wr_issue, push, pop, credit_ok;
   logic [CW:0]           used;
   // Reads still in the pin/Q stages hold a FIFO slot so the FIFO can never overflow.
   assign run         = state_q == RUN;
   assign used        = (CW+1)'(rd1_q) + (CW+1)'(rd2_q) + (CW+1)'(cnt_q);
   assign credit_ok   = used < (CW+1)'(RSP_DEPTH);
   assign bus.req_rdy = run & (bus.req_wr | credit_ok);
   assign acc         = bus.req_vld & bus.req_rdy;
   assign issue       = acc & (~bus.req_wr | (|bus.req_wmask));
   assign wr_issue    = issue & bus.req_wr;
   assign push        = rd2_q;
   assign pop         = bus.rsp_vld & bus.rsp_rdy;
   assign bus.rsp_vld   = cnt_q != '0;
   assign bus.rsp_rdata = fifo_q[rptr_q];
   assign init_done     = run;
`ifdef CT_SPSRAM_INIT_EN
   logic [ADDR_WIDTH:0] icnt_q;
   assign init_wr = state_q == INIT && !icnt_q[ADDR_WIDTH];
   assign init_a  = icnt_q[ADDR_WIDTH-1:0];
   always_ff @(posedge forever_cpuclk or negedge cpurst_b)
      if (!cpurst_b) icnt_q <= '0;
      else if (init_wr) icnt_q <= icnt_q + (ADDR_WIDTH+1)'(1);
   always_comb begin
      state_d = state_q == RST ? INIT : (state_q == INIT && icnt_q[ADDR_WIDTH]) ? RUN : state_q;
   end
`else
   assign init_wr = 1'b0;
   assign init_a  = '0;
   always_comb begin
      state_d = state_q == RST ? RUN : state_q;
   end
`endif
   always_ff @(posedge forever_cpuclk or negedge cpurst_b)
      if (!cpurst_b) state_q <= RST;
      else state_q <= state_d;
   always_comb begin
      cen_d  = ~(init_wr | issue);
      gwen_d = ~(init_wr | wr_issue);
      wen_d  = init_wr ? '0 : wr_issue ? ~bus.req_wmask : '1;
      a_d    = init_wr ? init_a : issue ? bus.req_addr : sram_a;
      d_d    = init_wr ? '0 : wr_issue ? bus.req_wdata : sram_d;
   end
   always_ff @(posedge forever_cpuclk or negedge cpurst_b)
      if (!cpurst_b) begin
         sram_cen  <= 1'b1;
         sram_gwen <= 1'b1;
         sram_wen  <= '1;
         sram_a    <= '0;
         sram_d    <= '0;
      end else begin
         sram_cen  <= cen_d;
         sram_gwen <= gwen_d;
         sram_wen  <= wen_d;
         sram_a    <= a_d;
         sram_d    <= d_d;
      end
   // rd1: read pins on the bus; rd2: Q valid this cycle and pushed at its end.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b)
      if (!cpurst_b) begin
         rd1_q  <= 1'b0;
         rd2_q  <= 1'b0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         rd1_q <= issue & ~bus.req_wr;
         rd2_q <= rd1_q;
         if (push) begin
            fifo_q[wptr_q] <= sram_q;
            wptr_q         <= wptr_q + PW'(1);
         end
         if (pop) rptr_q <= rptr_q + PW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
endmodule

// File: tb/tb_ct_spsram_512x52_ctrl.sv
// tb_ct_spsram_512x52_ctrl: directed and random traffic against a word-array reference and an SRAM macro model.
module tb_ct_spsram_512x52_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   ct_spsram_512x52_ctrl_if bus ();
   logic        init_done, sram_cen, sram_gwen;
   logic [8:0]  sram_a;
   logic [51:0] sram_wen, sram_d;
   logic [51:0] sram_q = '0;
   ct_spsram_512x52_ctrl dut (
      .forever_cpuclk(clk), .cpurst_b(rst_n), .bus(bus), .init_done(init_done),
      .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
      .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
   );
   logic [51:0] sram_mem [512];
   logic [51:0] ref_mem [512];
   logic [51:0] exp_q [$];
   logic        loaded = 1'b0;
   int checks = 0, errors = 0;
   // Macro model: per-bit active-low write enables, Q valid the cycle after a read.
   always @(posedge clk)
      if (!loaded) begin
         for (int i = 0; i < 512; i++) sram_mem[i] <= ref_mem[i];
         loaded <= 1'b1;
      end else if (!sram_cen) begin
         if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else sram_q <= sram_mem[sram_a];
      end
   function automatic logic [51:0] rnd52();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[51:0];
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   always @(negedge clk)
      if (rst_n && bus.rsp_vld && bus.rsp_rdy) begin
         chk("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) chk("rsp_data", 64'(bus.rsp_rdata), 64'(exp_q.pop_front()));
      end
   task automatic reset_chk(input string tag);
      chk({tag, "_ctl"}, 64'({sram_cen, sram_gwen, bus.req_rdy, bus.rsp_vld, init_done}), 64'b11000);
      chk({tag, "_wen"}, 64'(sram_wen), 64'hF_FFFF_FFFF_FFFF);
      chk({tag, "_a"}, 64'(sram_a), 64'd0);
      chk({tag, "_d"}, 64'(sram_d), 64'd0);
      chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
   endtask
   task automatic send(input logic wr, input logic [8:0] a, input logic [51:0] wd, input logic [51:0] wm, output int lat);
      logic acc;
      bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = wd; bus.req_wmask = wm; bus.req_vld = 1'b1;
      acc = 1'b0; lat = 0;
      while (!acc && lat < 100) begin
         @(negedge clk);
         acc = bus.req_rdy;
         @(posedge clk);
         lat++;
         if (!acc) begin #1; bus.rsp_rdy = 1'b1; end
      end
      chk("accept", 64'(acc), 64'd1);
      if (acc) begin
         if (wr) ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
         else exp_q.push_back(ref_mem[a]);
      end
      #1 bus.req_vld = 1'b0;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin @(posedge clk); n++; end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic sweep_check();
      int n;
      n = 0;
      bus.req_wr = 1'b1;
      @(negedge clk);
      while (sram_cen && n < 10) begin @(negedge clk); n++; end
      for (int i = 0; i < 512; i++) begin
         chk("sweep", 64'({sram_cen, sram_gwen, |sram_wen, |sram_d, bus.req_rdy, init_done, sram_a}), 64'(i));
         @(negedge clk);
      end
      chk("init_done_rise", 64'({init_done, sram_cen}), 64'b11);
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int lat;
      logic [51:0] wm;
      bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0;
      bus.rsp_rdy = 1'b1;
      for (int i = 0; i < 512; i++) ref_mem[i] = rnd52();
      #1 rst_n = 1'b0;
      #1 reset_chk("reset_async");
      repeat (3) @(negedge clk);
      reset_chk("reset");
      rst_n = 1'b1;
`ifdef CT_SPSRAM_INIT_EN
      sweep_check();
      send(1'b0, 9'h1FF, '0, '0, lat);
      drain();
`else
      chk("init_done_pre", 64'(init_done), 64'd0);
      @(negedge clk);
      chk("init_done_post", 64'({init_done, sram_cen}), 64'b11);
      repeat (3) begin @(negedge clk); chk("idle_cen", 64'(sram_cen), 64'd1); end
      @(posedge clk); #1;
`endif
      send(1'b1, 9'h0A0, 52'hA5A5A5A5A5A5A, '1, lat);
      send(1'b0, 9'h0A0, '0, '0, lat);
      @(negedge clk); chk("lat_t1", 64'(bus.rsp_vld), 64'd0);
      @(negedge clk); chk("lat_t2", 64'(bus.rsp_vld), 64'd0);
      @(negedge clk); chk("lat_t3", 64'({bus.rsp_vld, bus.rsp_rdata}), {12'd0, 1'b1, 52'hA5A5A5A5A5A5A});
      drain();
      send(1'b1, 9'h011, '1, 52'h0000003FFFFFF, lat);
      send(1'b0, 9'h011, '0, '0, lat);
      drain();
      send(1'b1, 9'h011, '0, '0, lat);
      @(negedge clk); chk("zero_mask_cen", 64'(sram_cen), 64'd1);
      @(negedge clk); chk("zero_mask_cen2", 64'(sram_cen), 64'd1);
      @(posedge clk); #1;
      send(1'b0, 9'h011, '0, '0, lat);
      drain();
      for (int i = 0; i < 6; i++) send(1'b1, 9'(i), rnd52(), '1, lat);
      bus.rsp_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 9'(i), '0, '0, lat);
         chk("stall_rd_lat", 64'(lat), 64'd1);
      end
      bus.req_wr = 1'b0; bus.req_addr = 9'd4; bus.req_vld = 1'b1;
      repeat (4) begin @(negedge clk); chk("credit_block", 64'(bus.req_rdy), 64'd0); end
      chk("fifo_full_vld", 64'(bus.rsp_vld), 64'd1);
      bus.req_vld = 1'b0;
      @(posedge clk); #1;
      send(1'b1, 9'd4, rnd52(), '1, lat);
      chk("stall_wr_lat", 64'(lat), 64'd1);
      bus.rsp_rdy = 1'b1;
      send(1'b0, 9'd4, '0, '0, lat);
      send(1'b0, 9'd5, '0, '0, lat);
      drain();
      repeat (80) begin
         bus.rsp_rdy = $urandom_range(0, 2) != 0;
         wm = $urandom_range(0, 4) == 0 ? '0 : rnd52();
         send(1'($urandom_range(0, 1)), 9'($urandom_range(0, 7)), rnd52(), wm, lat);
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      bus.rsp_rdy = 1'b1;
      drain();
`ifdef CT_SPSRAM_INIT_EN
      lat = 0;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      while (!(sram_a == 9'h100 && !sram_cen) && lat < 700) begin @(negedge clk); lat++; end
      chk("reach_0x100", 64'({sram_cen, sram_a}), 64'h100);
      rst_n = 1'b0;
      #1 reset_chk("reset_mid_init");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sweep_check();
      send(1'b0, 9'h0A0, '0, '0, lat);
      drain();
`else
      bus.rsp_rdy = 1'b0;
      send(1'b0, 9'd1, '0, '0, lat);
      send(1'b0, 9'd2, '0, '0, lat);
      @(negedge clk);
      rst_n = 1'b0;
      #1 reset_chk("reset_discard");
      exp_q.delete();
      bus.rsp_rdy = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(1'b0, 9'd3, '0, '0, lat);
      drain();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
